// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline sequencing controller for the 5-stage CPU.
//                Drives the PC enable, fetch/decode and decode/execute register
//                enables/flushes and the ex/mem bubble. Handles load-use
//                hazards, taken-branch flushes and multi-cycle EX operations
//                with a three-state FSM (RUN, BUSY, FLUSH), generates EX
//                operand-forwarding selects and keeps saturating stall/flush
//                performance counters.
//  Ports       :
//    clk, rst_n            clock (rising edge), synchronous active-low reset
//    id_rs1/id_rs2         decode-stage source registers
//    id_use_rs1/id_use_rs2 decode instruction reads rs1/rs2
//    ex_rd, ex_wr_en       EX-stage destination and write enable
//    ex_is_load            EX instruction is a load
//    ex_branch_taken       EX resolved a taken branch/jump (pulse)
//    ex_mc_start           EX instruction is multi-cycle (pulse)
//    ex_mc_cycles          total EX cycles of the multi-cycle instruction
//    mem_rd, mem_wr_en     MEM-stage destination and write enable
//    pc_en                 PC update enable
//    if_id_en/if_id_flush  fetch/decode register enable / NOP insert
//    id_ex_en/id_ex_flush  decode/execute register enable / bubble insert
//    ex_mem_bubble         ex/mem register captures a bubble
//    fwd_a_sel/fwd_b_sel   operand source: 00 regfile, 01 MEM, 10 EX
//    stall_cycles          saturating count of cycles with pc_en=0
//    flush_cycles          saturating count of cycles with if_id_flush=1
//    busy                  FSM is not in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
  parameter int FLUSH_EXTRA = 1,
  parameter int CNT_W       = 16,
  parameter int MC_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic [MC_W-1:0]  ex_mc_cycles,
  input  logic [4:0]       mem_rd,
  input  logic             mem_wr_en,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic             busy
);

  localparam int c_fl_w = (FLUSH_EXTRA < 2) ? 1 : $clog2(FLUSH_EXTRA + 1);
  localparam logic [c_fl_w-1:0] c_fl_reload = c_fl_w'(FLUSH_EXTRA);
  localparam logic [MC_W-1:0]   c_mc_two    = MC_W'(2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MC_W-1:0]   r_mc_cnt;
  logic [MC_W-1:0]   w_mc_nxt;
  logic [c_fl_w-1:0] r_fl_cnt;
  logic [c_fl_w-1:0] w_fl_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_load_use;
  logic w_mc_long;

  assign w_load_use = ex_is_load & ex_wr_en & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

  assign w_mc_long  = ex_mc_start & (ex_mc_cycles >= c_mc_two);

  // Forwarding select: EX result wins over MEM; a load in EX has no data yet
  // and x0 is hard-wired zero so it is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_wr_en && !ex_is_load && (ex_rd != 5'd0) && (ex_rd == rs)) begin
      sel = 2'b10;
    end else if (mem_wr_en && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_nxt;
      r_fl_cnt <= w_fl_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mc_nxt      = r_mc_cnt;
    w_fl_nxt      = r_fl_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    fwd_a_sel     = fwd_sel(id_rs1);
    fwd_b_sel     = fwd_sel(id_rs2);

    case (r_state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_EXTRA > 0) begin
            w_state_nxt = ST_FLUSH;
            w_fl_nxt    = c_fl_reload;
          end
        end else if (w_mc_long) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_bubble = 1'b1;
          // mc_cnt holds the number of BUSY cycles still to come. This start
          // cycle is already one stall, so a 2-cycle op needs no BUSY visit.
          w_mc_nxt      = ex_mc_cycles - c_mc_two;
          if (ex_mc_cycles != c_mc_two) begin
            w_state_nxt = ST_BUSY;
          end
        end else if (w_load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      ST_BUSY: begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
        if (r_mc_cnt <= MC_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_mc_nxt    = '0;
        end else begin
          w_mc_nxt = r_mc_cnt - MC_W'(1);
        end
      end

      ST_FLUSH: begin
        if_id_flush = 1'b1;
        if (ex_branch_taken) begin
          id_ex_flush = 1'b1;
          w_fl_nxt    = c_fl_reload;
        end else if (r_fl_cnt <= c_fl_w'(1)) begin
          w_state_nxt = ST_RUN;
          w_fl_nxt    = '0;
        end else begin
          w_fl_nxt = r_fl_cnt - c_fl_w'(1);
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // While reset is held the pipeline is frozen and filled with bubbles.
    if (!rst_n) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
      fwd_a_sel     = 2'b00;
      fwd_b_sel     = 2'b00;
    end
  end

  assign busy = rst_n & (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Scoreboard bench for hazard_stall_ctrl. A stimulus process
//                drives one cycle of inputs, predicts the outputs with a
//                cycle-count reference model and queues them; a monitor pops
//                and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

  localparam int FLUSH_EXTRA = 1;
  localparam int CNT_W       = 4;
  localparam int MC_W        = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_wr_en, ex_is_load, ex_branch_taken, ex_mc_start;
  logic [MC_W-1:0]  ex_mc_cycles;
  logic             mem_wr_en;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic             ex_mem_bubble, busy;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .FLUSH_EXTRA(FLUSH_EXTRA),
    .CNT_W(CNT_W),
    .MC_W(MC_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .mem_rd(mem_rd),
    .mem_wr_en(mem_wr_en),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles),
    .busy(busy)
  );

  typedef struct {
    logic            rst_n;
    logic [4:0]      id_rs1, id_rs2, ex_rd, mem_rd;
    logic            id_use_rs1, id_use_rs2;
    logic            ex_wr_en, ex_is_load, ex_branch_taken, ex_mc_start;
    logic [MC_W-1:0] ex_mc_cycles;
    logic            mem_wr_en;
  } stim_t;

  typedef struct {
    int   cyc;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_bubble;
    logic [1:0] fwd_a, fwd_b;
    int   stall, flush;
    logic busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: remaining stall / flush cycles and event counts.
  int m_stall_left = 0;
  int m_flush_left = 0;
  int m_stall_cnt  = 0;
  int m_flush_cnt  = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.ex_wr_en && !s.ex_is_load && s.ex_rd != 0 && s.ex_rd == rs) return 2'b10;
    if (s.mem_wr_en && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic predict(input stim_t s, output exp_t e);
    bit hazard;
    e.cyc   = cyc;
    e.stall = m_stall_cnt;
    e.flush = m_flush_cnt;
    e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1;
    e.if_id_flush = 0; e.id_ex_flush = 0; e.ex_mem_bubble = 0;
    e.fwd_a = ref_fwd(s.id_rs1, s);
    e.fwd_b = ref_fwd(s.id_rs2, s);
    e.busy  = (m_stall_left > 0) || (m_flush_left > 0);
    if (!s.rst_n) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0;
      e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_bubble = 1;
      e.fwd_a = 0; e.fwd_b = 0; e.busy = 0;
      m_stall_left = 0; m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      return;
    end
    hazard = s.ex_is_load && s.ex_wr_en && s.ex_rd != 0 &&
             ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) ||
              (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
    if (m_stall_left > 0) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_bubble = 1;
      m_stall_left--;
    end else if (m_flush_left > 0) begin
      e.if_id_flush = 1;
      if (s.ex_branch_taken) begin
        e.id_ex_flush = 1;
        m_flush_left  = FLUSH_EXTRA;
      end else begin
        m_flush_left--;
      end
    end else if (s.ex_branch_taken) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
      m_flush_left  = FLUSH_EXTRA;
    end else if (s.ex_mc_start && s.ex_mc_cycles >= 2) begin
      // Total stall = cycles-1; this cycle is the first of them.
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0; e.ex_mem_bubble = 1;
      m_stall_left = int'(s.ex_mc_cycles) - 2;
    end else if (hazard) begin
      e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
    end
    if (!e.pc_en && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (e.if_id_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, expv);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pc_en",         e.cyc, 32'(pc_en),         32'(e.pc_en));
        chk("if_id_en",      e.cyc, 32'(if_id_en),      32'(e.if_id_en));
        chk("if_id_flush",   e.cyc, 32'(if_id_flush),   32'(e.if_id_flush));
        chk("id_ex_en",      e.cyc, 32'(id_ex_en),      32'(e.id_ex_en));
        chk("id_ex_flush",   e.cyc, 32'(id_ex_flush),   32'(e.id_ex_flush));
        chk("ex_mem_bubble", e.cyc, 32'(ex_mem_bubble), 32'(e.ex_mem_bubble));
        chk("fwd_a_sel",     e.cyc, 32'(fwd_a_sel),     32'(e.fwd_a));
        chk("fwd_b_sel",     e.cyc, 32'(fwd_b_sel),     32'(e.fwd_b));
        chk("stall_cycles",  e.cyc, 32'(stall_cycles),  32'(e.stall));
        chk("flush_cycles",  e.cyc, 32'(flush_cycles),  32'(e.flush));
        chk("busy",          e.cyc, 32'(busy),          32'(e.busy));
      end
    end
  end

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = s.rst_n;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.id_use_rs1; id_use_rs2 = s.id_use_rs2;
    ex_rd = s.ex_rd; ex_wr_en = s.ex_wr_en; ex_is_load = s.ex_is_load;
    ex_branch_taken = s.ex_branch_taken; ex_mc_start = s.ex_mc_start;
    ex_mc_cycles = s.ex_mc_cycles;
    mem_rd = s.mem_rd; mem_wr_en = s.mem_wr_en;
    predict(s, e);
    sb.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n           = ($urandom_range(0, 99) != 0);
    s.id_rs1          = 5'($urandom_range(0, 3));
    s.id_rs2          = 5'($urandom_range(0, 3));
    s.ex_rd           = 5'($urandom_range(0, 3));
    s.mem_rd          = 5'($urandom_range(0, 3));
    s.id_use_rs1      = 1'($urandom_range(0, 1));
    s.id_use_rs2      = 1'($urandom_range(0, 1));
    s.ex_wr_en        = 1'($urandom_range(0, 1));
    s.ex_is_load      = 1'($urandom_range(0, 1));
    s.mem_wr_en       = 1'($urandom_range(0, 1));
    s.ex_branch_taken = ($urandom_range(0, 9) == 0);
    s.ex_mc_start     = ($urandom_range(0, 9) == 0);
    s.ex_mc_cycles    = MC_W'($urandom_range(0, 6));
    return s;
  endfunction

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) drive(idle());
  endtask

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_wr_en = 0; ex_is_load = 0; ex_branch_taken = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; mem_rd = 0; mem_wr_en = 0;
    @(posedge clk);

    // Reset with random inputs, then release.
    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.rst_n = 1'b0; drive(s);
    end
    idles(2);

    // Load-use on rs2, then the same with x0 as destination.
    s = idle(); s.ex_is_load = 1; s.ex_wr_en = 1; s.ex_rd = 5; s.id_rs2 = 5;
    s.id_use_rs2 = 1; drive(s);
    idles(1);
    s.ex_rd = 0; s.id_rs2 = 0; drive(s);
    idles(1);

    // Forwarding priority.
    s = idle(); s.ex_rd = 3; s.mem_rd = 3; s.ex_wr_en = 1; s.mem_wr_en = 1;
    s.id_rs1 = 3; drive(s);
    s.ex_wr_en = 0; drive(s);
    s.id_rs1 = 0; drive(s);

    // Multi-cycle ops of length 4, 1 and 2.
    s = idle(); s.ex_mc_start = 1; s.ex_mc_cycles = 4; drive(s); idles(4);
    s.ex_mc_cycles = 1; drive(s); idles(1);
    s.ex_mc_cycles = 2; drive(s); idles(2);

    // Branch, branch with simultaneous mc_start, back-to-back branches.
    s = idle(); s.ex_branch_taken = 1; drive(s); idles(3);
    s.ex_mc_start = 1; s.ex_mc_cycles = 5; drive(s); idles(3);
    s = idle(); s.ex_branch_taken = 1; drive(s); drive(s); idles(3);

    // Reset in the middle of a long BUSY.
    s = idle(); s.ex_mc_start = 1; s.ex_mc_cycles = 8; drive(s); idles(2);
    s = idle(); s.rst_n = 0; drive(s); idles(3);

    // Stall counter saturation.
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.ex_mc_start = 1; s.ex_mc_cycles = 15; drive(s); idles(15);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) drive(rnd());

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
